// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: tracks EXE/MEM/WB destinations, raises stall/flush to IF/ID and registers EXE forwarding selects
module id_hazard_scoreboard #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             src1_valid,
  input  logic             src2_valid,
  input  logic             is_branch,
  input  logic [4:0]       Dest,
  input  logic             WB_EN,
  input  logic             MEM_R_EN,
  input  logic             Br_taken,
  input  logic             freeze,
  output logic             hazard_stall,
  output logic             flush,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_count
);
  typedef struct packed {
    logic [4:0] dest;
    logic       wb;
    logic       ld;
  } entry_t;
  // sb[0] = exe, sb[1] = mem, sb[2] = wb
  entry_t sb [3];
  logic m1e, m1m, m2e, m2m, raw;
  function automatic logic hit(entry_t e, logic [4:0] s, logic v);
    return v & e.wb & (e.dest == s) & (s != 5'd0);
  endfunction
  assign m1e = hit(sb[0], src1, src1_valid);
  assign m1m = hit(sb[1], src1, src1_valid);
  assign m2e = hit(sb[0], src2, src2_valid);
  assign m2m = hit(sb[1], src2, src2_valid);
  assign raw = FORWARD_EN ? (((m1e | m2e) & sb[0].ld) | (is_branch & (m1e | m2e | m1m | m2m)))
                          : (m1e | m2e | m1m | m2m);
  assign hazard_stall = rst & ~freeze & raw;
  assign flush = rst & Br_taken & ~hazard_stall & ~freeze;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb[0] <= '0;
      sb[1] <= '0;
      sb[2] <= '0;
      fwd_sel1 <= 2'd0;
      fwd_sel2 <= 2'd0;
      stall_count <= '0;
    end else if (!freeze) begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= hazard_stall ? entry_t'('0) : entry_t'{Dest, WB_EN, MEM_R_EN};
      fwd_sel1 <= (hazard_stall || !FORWARD_EN) ? 2'd0 : m1e ? 2'd1 : m1m ? 2'd2 : 2'd0;
      fwd_sel2 <= (hazard_stall || !FORWARD_EN) ? 2'd0 : m2e ? 2'd1 : m2m ? 2'd2 : 2'd0;
      stall_count <= stall_count + CNT_W'(hazard_stall && !(&stall_count));
    end
  end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Responder side of the decode stage's source/destination interface.
- Consumes the decode stage's src1/src2/Dest and control outputs every cycle.
- Internally tracks destinations in flight in the EXE, MEM and WB stages.
- Returns stall and flush to IF/ID and registered forwarding selects aligned to the EXE stage; sits beside the ID/EXE pipeline register.

Parameters:
FORWARD_EN, 1, 1 = forward from MEM/WB and stall only on load-use or branch RAW; 0 = stall on any RAW against EXE/MEM entries
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous reset, active-low
src1  input  5  first source register of instruction in ID
src2  input  5  second source register of instruction in ID
src1_valid  input  1  instruction in ID reads src1
src2_valid  input  1  instruction in ID reads src2 (R-type, ST, BNE)
is_branch  input  1  instruction in ID is a branch (compares in ID)
Dest  input  5  destination of instruction in ID
WB_EN  input  1  instruction in ID writes back
MEM_R_EN  input  1  instruction in ID is a load
Br_taken  input  1  branch resolved taken in ID
freeze  input  1  global pipeline freeze (memory wait)
hazard_stall  output  1  hold PC and IF/ID; insert bubble into ID/EXE
flush  output  1  squash IF/ID contents
fwd_sel1  output  2  EXE operand-1 select: 0 = register value, 1 = MEM-stage ALU result, 2 = WB-stage value
fwd_sel2  output  2  same encoding for operand 2 / store data
stall_count  output  CNT_W  number of stall cycles since reset

Behaviour:
- Scoreboard: three entries, exe/mem/wb, each holding {dest[4:0], wb, ld}.
- Reset (rst low, async): all entries cleared (wb = 0, ld = 0, dest = 0); fwd_sel1 = fwd_sel2 = 0; stall_count = 0.
- hazard_stall and flush are combinational and evaluate to 0 while in reset.
- Match: for source s, match_X(s) = s_valid & entry_X.wb & (entry_X.dest == s) & (s != 0). Register 0 never matches.
- hazard_stall, FORWARD_EN = 1: asserted if either source has match_exe with exe.ld = 1 (load-use), or if is_branch and either source has match_exe or match_mem.
- hazard_stall, FORWARD_EN = 0: asserted if either source has match_exe or match_mem.
- A match against the wb entry never stalls; the register file writes before it reads.
- hazard_stall and flush are both forced to 0 while freeze = 1.
- flush = Br_taken & ~hazard_stall & ~freeze.
- Per rising clk edge, freeze = 1: entries, fwd_sel outputs and stall_count all hold.
- Per rising clk edge, no freeze: wb <= mem and mem <= exe.
  - If hazard_stall: exe <= bubble (wb = 0, ld = 0, dest = 0).
  - Otherwise: exe <= {Dest, WB_EN, MEM_R_EN}.
- Forward selects, registered at the same edge. With hazard_stall = 1 or FORWARD_EN = 0, fwd_selN <= 0. Otherwise, per source:
  - match_exe -> 1;
  - else match_mem -> 2;
  - else 0.
  - exe takes priority over mem (youngest producer wins).
- Forward-select latency: one cycle; the selects apply to the instruction entering EXE on that edge.
- Load-use sequence: one stall cycle. On the following cycle the load sits in the mem entry, so the dependent instruction gets fwd_sel = 2.
- stall_count: increments on each non-frozen edge with hazard_stall = 1; saturates at all-ones and never wraps.
- Simultaneous Br_taken and hazard_stall: the stall wins and flush = 0. The branch re-evaluates next cycle.
- A flushed branch itself is issued normally into the exe entry.
- Bubbles never match because wb = 0.

Test Plan:
- rst low mid-stream with entries loaded -> all outputs 0 immediately; after release, an instruction reading r3 behind a pre-reset producer of r3 shows no stall and fwd_sel1 = 0.
- FORWARD_EN = 1: ADD r3 then ADD src1 = r3 back-to-back -> hazard_stall = 0; fwd_sel1 = 1 at the next edge; a third instruction reading r3 gets fwd_sel1 = 2.
- FORWARD_EN = 1: LD r5 (MEM_R_EN = 1) then use src2 = r5 -> hazard_stall = 1 for exactly 1 cycle; exe entry becomes a bubble; next edge fwd_sel2 = 2; stall_count = 1.
- Producer with Dest = r0 and WB_EN = 1 followed by reader of r0 -> no stall; fwd_sel1 = fwd_sel2 = 0.
- BNE (is_branch = 1) reading r7 directly after ADD r7 with Br_taken = 1 -> 2 stall cycles and flush = 0 during them; on the 3rd cycle flush = 1; stall_count = 2.
- FORWARD_EN = 0: ADD r4 then reader of r4 -> 2 stall cycles, fwd_sel = 0 throughout.
- freeze = 1 during the stall window -> hazard_stall = 0, stall_count holds, entries hold.
